// File: rtl/shift_seq_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative shift sequencer.
package shift_seq_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef enum logic [1:0] {
        SHOP_SLL  = 2'b00,
        SHOP_SRL  = 2'b01,
        SHOP_SRA  = 2'b10,
        SHOP_PASS = 2'b11
    } shop_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Two requester channels plus the tagged response channel of the shift sequencer.
interface shift_seq_if;
    import shift_seq_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [SHW-1:0]   req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [SHW-1:0]   req1_b;
    logic [1:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, busy,
        input  rsp_ready
    );

endinterface

// File: rtl/shift_seq_stage.sv
// Single reusable binary shift stage: shifts acc by 2^k according to op.
module shift_stage
    import shift_seq_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [2:0]       k,
    input  shop_e            op,
    output logic [WIDTH-1:0] shifted
);

    logic [5:0]       sh;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] sign_mask;

    always_comb begin
        sh        = 6'd1 << k;
        ones      = '1;
        // Bits vacated by a right shift; filled with the MSB for SRA.
        sign_mask = ~(ones >> sh);
        shifted   = acc;
        case (op)
            SHOP_SLL: shifted = acc << sh;
            SHOP_SRL: shifted = acc >> sh;
            SHOP_SRA: shifted = (acc >> sh) | (acc[WIDTH-1] ? sign_mask : '0);
            default:  shifted = acc;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Round-robin two-port arbiter and 5-stage iterative sequencer for a shared shifter.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    shift_seq_if.slave bus
);

    state_e           state_q;
    logic [2:0]       k_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   amt_q;
    shop_e            op_q;
    logic             id_q;
    logic             rr_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             busy_q;

    logic             gnt_vld;
    logic             gnt_id_d;
    logic [WIDTH-1:0] sel_a;
    logic [SHW-1:0]   sel_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] stage_acc;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        gnt_id_d = 1'b0;
        case ({bus.req1_valid, bus.req0_valid})
            2'b01:   gnt_id_d = 1'b0;
            2'b10:   gnt_id_d = 1'b1;
            2'b11:   gnt_id_d = rr_q;
            default: gnt_id_d = 1'b0;
        endcase
        gnt_vld        = (bus.req0_valid | bus.req1_valid) & (state_q == IDLE) & ~rst;
        bus.req0_ready = gnt_vld & ~gnt_id_d;
        bus.req1_ready = gnt_vld & gnt_id_d;
        sel_a          = gnt_id_d ? bus.req1_a  : bus.req0_a;
        sel_b          = gnt_id_d ? bus.req1_b  : bus.req0_b;
        sel_op         = gnt_id_d ? bus.req1_op : bus.req0_op;
    end

    shift_stage u_stage (
        .acc     (acc_q),
        .k       (k_q),
        .op      (op_q),
        .shifted (stage_acc)
    );

    // The amount is consumed LSB-first, so amt_q[0] always selects the current stage.
    assign acc_d = amt_q[0] ? stage_acc : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            amt_q       <= '0;
            op_q        <= SHOP_PASS;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        acc_q   <= sel_a;
                        amt_q   <= sel_b;
                        op_q    <= shop_e'(sel_op);
                        id_q    <= gnt_id_d;
                        k_q     <= '0;
                        rr_q    <= ~gnt_id_d;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    amt_q <= amt_q >> 1;
                    if (k_q == 3'd4) begin
                        k_q         <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= acc_d;
                        rsp_id_q    <= id_q;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq: shifts, arbitration, backpressure, reset.
module tb_shift_seq;
    import shift_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shift_seq_if bus ();

    shift_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive_req(input logic id, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    // Issues one request, waits for the response and consumes it; returns observations.
    task automatic run_one(input logic id, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op,
                           output logic [31:0] data, output logic rid, output int lat, output int wait_cyc);
        data = '0; rid = 1'b0; lat = -1; wait_cyc = -1;
        @(negedge clk);
        drive_req(id, a, b, op);
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                wait_cyc = i;
                break;
            end
            @(negedge clk);
        end
        if (wait_cyc >= 0) begin
            @(posedge clk);
            @(negedge clk);
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            for (int n = 0; n <= 20; n++) begin
                if (bus.rsp_valid === 1'b1) begin
                    lat = n;
                    break;
                end
                @(negedge clk);
            end
            if (lat >= 0) begin
                data = bus.rsp_data;
                rid  = bus.rsp_id;
                bus.rsp_ready = 1'b1;
                @(negedge clk);
                bus.rsp_ready = 1'b0;
            end
        end else begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00000000", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b expected 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b expected 0", bus.req1_ready); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sll();
        logic [31:0] d; logic r; int lat; int w;
        run_one(1'b0, 32'h0000_0001, 5'd31, SHOP_SLL, d, r, lat, w);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL sll31_data: got %h expected 80000000", d); end
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL sll31_id: got %b expected 0", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sll31_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_sra_srl();
        logic [31:0] d; logic r; int lat; int w;
        run_one(1'b1, 32'h8000_0000, 5'd4, SHOP_SRA, d, r, lat, w);
        checks++; if (d !== 32'hF800_0000) begin errors++; $display("FAIL sra4_data: got %h expected f8000000", d); end
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL sra4_id: got %b expected 1", r); end
        run_one(1'b1, 32'h8000_0000, 5'd4, SHOP_SRL, d, r, lat, w);
        checks++; if (d !== 32'h0800_0000) begin errors++; $display("FAIL srl4_data: got %h expected 08000000", d); end
        run_one(1'b1, 32'h8000_0000, 5'd4, SHOP_PASS, d, r, lat, w);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL pass_data: got %h expected 80000000", d); end
        run_one(1'b1, 32'h8000_0000, 5'd0, SHOP_SLL, d, r, lat, w);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL sll0_data: got %h expected 80000000", d); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sll0_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_arbitration();
        int gid[4]; int gcyc[4]; logic rid[4]; logic [31:0] rdat[4];
        int ng = 0; int nr = 0;
        int exp_id[4] = '{0, 1, 0, 1};
        logic [31:0] exp_dat[4] = '{32'h2, 32'h8, 32'h2, 32'h8};
        logic [31:0] d; logic r; int lat; int w;
        for (int i = 0; i < 4; i++) begin gid[i] = -1; gcyc[i] = -100; rid[i] = 1'bx; rdat[i] = 'x; end
        rst = 1'b1;
        drive_req(1'b0, 32'h0000_0001, 5'd1, SHOP_SLL);
        drive_req(1'b1, 32'h0000_0010, 5'd1, SHOP_SRL);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (ng < 4 && bus.req0_ready === 1'b1) begin gid[ng] = 0; gcyc[ng] = c; ng++; end
            else if (ng < 4 && bus.req1_ready === 1'b1) begin gid[ng] = 1; gcyc[ng] = c; ng++; end
            if (nr < 4 && bus.rsp_valid === 1'b1) begin rid[nr] = bus.rsp_id; rdat[nr] = bus.rsp_data; nr++; end
            if (ng == 4 && nr == 4) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (gid[i] !== exp_id[i]) begin errors++; $display("FAIL arb_grant%0d: got %0d expected %0d", i, gid[i], exp_id[i]); end
            checks++; if (rid[i] !== exp_id[i][0]) begin errors++; $display("FAIL arb_rsp_id%0d: got %b expected %0d", i, rid[i], exp_id[i]); end
            checks++; if (rdat[i] !== exp_dat[i]) begin errors++; $display("FAIL arb_rsp_data%0d: got %h expected %h", i, rdat[i], exp_dat[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (gcyc[i] - gcyc[i-1] !== 7) begin errors++; $display("FAIL arb_interval%0d: got %0d expected 7", i, gcyc[i] - gcyc[i-1]); end
        end
        // rr pointer is back at 0 here; a lone req1 must still be granted at once.
        run_one(1'b1, 32'h0000_0100, 5'd2, SHOP_SRA, d, r, lat, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL lone_req1_wait: got %0d expected 0", w); end
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL lone_req1_id: got %b expected 1", r); end
        checks++; if (d !== 32'h0000_0040) begin errors++; $display("FAIL lone_req1_data: got %h expected 00000040", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; logic id0; int got = -1;
        @(negedge clk);
        drive_req(1'b0, 32'h1234_5678, 5'd8, SHOP_SRL);
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_ready: got %b expected 1", bus.req0_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        for (int n = 0; n <= 20; n++) begin
            if (bus.rsp_valid === 1'b1) begin got = n; break; end
            @(negedge clk);
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_latency: got %0d expected 5", got); end
        d0 = bus.rsp_data; id0 = bus.rsp_id;
        checks++; if (d0 !== 32'h0012_3456) begin errors++; $display("FAIL bp_data: got %h expected 00123456", d0); end
        checks++; if (id0 !== 1'b0) begin errors++; $display("FAIL bp_id: got %b expected 0", id0); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== 32'h0012_3456) begin errors++; $display("FAIL bp_hold_data%0d: got %h expected 00123456", i, bus.rsp_data); end
            checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL bp_hold_id%0d: got %b expected 0", i, bus.rsp_id); end
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_hold_ready%0d: got %b%b expected 00", i, bus.req0_ready, bus.req1_ready); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_hold_busy%0d: got %b expected 1", i, bus.busy); end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_consumed_busy: got %b expected 0", bus.busy); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_resume_ready: got %b%b expected 01", bus.req0_ready, bus.req1_ready); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic r; int lat; int w; int spurious = 0;
        @(negedge clk);
        drive_req(1'b1, 32'hFFFF_FFFF, 5'd31, SHOP_SLL);
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b expected 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL mid_data_async: got %h expected 00000000", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL mid_id_async: got %b expected 0", bus.rsp_id); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL mid_no_response: got %0d active cycles expected 0", spurious); end
        run_one(1'b0, 32'h0000_FFFF, 5'd16, SHOP_SLL, d, r, lat, w);
        checks++; if (d !== 32'hFFFF_0000) begin errors++; $display("FAIL post_reset_data: got %h expected ffff0000", d); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL post_reset_latency: got %0d expected 5", lat); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
